// File: rtl/irq_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : irq_controller                                               |
// | Description : Priority interrupt controller for the CPU interrupt          |
// |               handshake. Latches peripheral requests, selects the          |
// |               highest-priority enabled source at an instruction boundary,  |
// |               issues irq_det / irq_vec / irq_ack, and tracks RETI so that  |
// |               one instruction always runs between back-to-back interrupts. |
// | Config      : IRQ_LEVEL_EN - level-sensitive pending bits (default: edge   |
// |               latched, write-1-to-clear, cleared by acknowledge).          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module irq_controller #(
  parameter int          NUM_IRQ    = 8,
  parameter logic [15:0] VEC_BASE   = 16'h0000,
  parameter logic [15:0] VEC_STRIDE = 16'h0002
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               sr_if,
  input  logic               tim_accept,
  input  logic               irq_ret,
  input  logic               mm_ien_we,
  input  logic               mm_ipend_we,
  input  logic [7:0]         mm_io_wdata,
  output logic               irq_det,
  output logic [15:0]        irq_vec,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [7:0]         ien,
  output logic [7:0]         ipend,
  output logic               in_isr
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_ACCEPT   = 2'd1;
  localparam logic [1:0] c_RET_WAIT = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [NUM_IRQ-1:0] r_ien;
  logic [NUM_IRQ-1:0] r_ipend;
  logic [NUM_IRQ-1:0] w_ipend_next;
  logic [NUM_IRQ-1:0] w_req;
  logic [NUM_IRQ-1:0] w_sel_onehot;
  logic [2:0]         w_sel;
  logic               w_any;
  logic               w_qualify;
  logic               w_take;
  logic               w_det;
  logic [15:0]        w_sel_p1;
  logic [15:0]        w_vec;
  logic [15:0]        r_irq_vec;
  logic [NUM_IRQ-1:0] r_irq_ack;
  logic [3:0]         r_depth;

`ifdef IRQ_LEVEL_EN
  // Level mode: pending simply mirrors the request lines one cycle late.
  always_comb begin
    w_ipend_next = irq_src;
  end
`else
  logic [NUM_IRQ-1:0] r_src_d;
  logic [NUM_IRQ-1:0] w_clr;

  // Edge mode: rising edges set, acknowledge or W1C clears, set wins a tie.
  always_comb begin
    w_clr        = r_irq_ack | (mm_ipend_we ? mm_io_wdata[NUM_IRQ-1:0] : '0);
    w_ipend_next = (r_ipend & ~w_clr) | (irq_src & ~r_src_d);
  end

  // Delayed copy of the request lines for edge detection.
  always_ff @(posedge clock) begin
    if (!reset) r_src_d <= '0;
    else        r_src_d <= irq_src;
  end
`endif

  // Enable and pending registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ien   <= '0;
      r_ipend <= '0;
    end else begin
      if (mm_ien_we) r_ien <= mm_io_wdata[NUM_IRQ-1:0];
      r_ipend <= w_ipend_next;
    end
  end

  assign w_req     = r_ipend & r_ien;
  assign w_qualify = tim_accept & sr_if & w_any;

  // Priority encoder: lowest set index of the enabled pending requests wins.
  always_comb begin
    w_sel = 3'd0;
    w_any = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_sel = 3'(i);
        w_any = 1'b1;
      end
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_sel_onehot[i] = (w_sel == 3'(i));
    end
  end

  // Vector table entry 0 is the reset vector, so source n lives at entry n+1.
  assign w_sel_p1 = {13'd0, w_sel} + 16'd1;
  assign w_vec    = VEC_BASE + w_sel_p1 * VEC_STRIDE;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; RETI overrides everything and forces the one-instruction gap.
  always_comb begin
    w_state_next = r_state;
    if (irq_ret) begin
      w_state_next = c_RET_WAIT;
    end else begin
      case (r_state)
        c_IDLE:     w_state_next = w_qualify ? c_ACCEPT : c_IDLE;
        c_ACCEPT:   w_state_next = c_IDLE;
        c_RET_WAIT: w_state_next = tim_accept ? c_IDLE : c_RET_WAIT;
        default:    w_state_next = c_IDLE;
      endcase
    end
  end

  // Output decode: detect pulse while in ACCEPT, take when leaving IDLE for ACCEPT.
  always_comb begin
    w_det  = (r_state == c_ACCEPT);
    w_take = (r_state == c_IDLE) && (w_state_next == c_ACCEPT);
  end

  // Vector and acknowledge are captured at the qualifying edge; the vector holds afterwards.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_irq_vec <= 16'h0000;
      r_irq_ack <= '0;
    end else begin
      if (w_take) r_irq_vec <= w_vec;
      r_irq_ack <= w_take ? w_sel_onehot : '0;
    end
  end

  // Nesting depth: +1 per accept, -1 per RETI, both together cancel, saturating 0..15.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_depth <= 4'd0;
    end else begin
      case ({w_det, irq_ret})
        2'b10:   if (r_depth != 4'hF) r_depth <= r_depth + 4'd1;
        2'b01:   if (r_depth != 4'h0) r_depth <= r_depth - 4'd1;
        default: r_depth <= r_depth;
      endcase
    end
  end

  assign irq_det = w_det;
  assign irq_vec = r_irq_vec;
  assign irq_ack = r_irq_ack;
  assign ien     = 8'(r_ien);
  assign ipend   = 8'(r_ipend);
  assign in_isr  = (r_depth != 4'd0);

endmodule
`default_nettype wire
